cacheline_adaptor: RTL and testbench

- Sits directly downstream of the L1 caches' physical-memory port.
- Converts one 256-bit cacheline read or writeback request into a 4-beat, 64-bit burst on the memory bus.
- Returns the assembled 256-bit line, or the write completion, to the cache with a single-cycle response.
- Holds the line-aligned burst address stable for the whole transaction.

---
 rtl/cacheline_adaptor.sv | 141 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// 256-bit cacheline <-> 4x64-bit memory burst adaptor.
// Optional beat timeout via `define CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i,
  output logic              error_o
);

  localparam int num_beats = s_line / s_burst;
  localparam int CW = $clog2(num_beats);
  localparam logic [31:0] OFF_MASK = 32'(s_line / 8 - 1);
  localparam logic [CW-1:0] LAST = CW'(num_beats - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [s_line-1:0] line_q, line_d;
  logic [s_line-1:0] wbuf_q, wbuf_d;
  logic [31:0]       addr_q, addr_d;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic [7:0] idle_q, idle_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    wbuf_d  = wbuf_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        // Write has priority when both requests are raised.
        if (write_i) begin
          addr_d  = address_i & ~OFF_MASK;
          wbuf_d  = line_i;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = address_i & ~OFF_MASK;
          state_d = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[int'(cnt_q)*s_burst +: s_burst] = burst_i;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    idle_d = '0;
    err_d  = 1'b0;
    if ((state_q == READ || state_q == WRITE) && !resp_i) begin
      idle_d = idle_q + 8'd1;
      if (idle_d == 8'(TIMEOUT)) begin
        state_d = DONE;
        err_d   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      wbuf_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      wbuf_q  <= wbuf_d;
      addr_q  <= addr_d;
    end
  end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign burst_o   = wbuf_q[int'(cnt_q)*s_burst +: s_burst];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: reads, writes,
// stalled bursts, priority, async reset and optional timeout.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i, error_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];

  always #5 clk = ~clk;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  cacheline_adaptor #(.TIMEOUT(8)) dut (
`else
  cacheline_adaptor dut (
`endif
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o),
    .write_o(write_o), .resp_i(resp_i),
    .error_o(error_o)
  );

  task automatic test_reset();
    rst = 1'b0; read_i = 0; write_i = 0; resp_i = 0;
    line_i = '0; address_i = '0; burst_i = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({read_o, write_o, resp_o, error_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=0000",
               {read_o, write_o, resp_o, error_o});
    end
    n_checks++;
    if (address_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr got=%h want=0", address_o);
    end
    n_checks++;
    if (line_o !== 256'h0) begin
      n_fail++;
      $display("FAIL reset_line got=%h want=0", line_o);
    end
    n_checks++;
    if (burst_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_burst got=%h want=0", burst_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_txn(input string nm, input logic [31:0] addr,
                          input logic [255:0] line,
                          input logic [31:0] pat, input int plen,
                          input bit toggle_addr);
    logic [31:0]  ea;
    logic [255:0] el;
    int beat, i, cyc;
    ea = {addr[31:5], 5'b0};
    beat = 0; i = 0; cyc = 0;
    address_i = addr;
    read_i = 1'b1;
    exp_line_q.push_back(line);
    @(negedge clk);
    while (beat < 4 && cyc < 64) begin
      n_checks++;
      if ({read_o, write_o, resp_o} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s busy_flags cyc=%0d got=%b want=100",
                 nm, cyc, {read_o, write_o, resp_o});
      end
      n_checks++;
      if (address_o !== ea) begin
        n_fail++;
        $display("FAIL %s addr cyc=%0d got=%h want=%h",
                 nm, cyc, address_o, ea);
      end
      resp_i = (i < plen) ? pat[i] : 1'b1;
      i++;
      if (resp_i) begin
        burst_i = line[beat*64 +: 64];
        beat++;
      end else begin
        burst_i = {$urandom, $urandom};
      end
      if (toggle_addr) address_i = $urandom;
      @(negedge clk);
      cyc++;
    end
    resp_i = 1'b0;
    n_checks++;
    if (beat < 4) begin
      n_fail++;
      $display("FAIL %s burst_timeout got=%0d want=4 beats", nm, beat);
    end
    n_checks++;
    if ({resp_o, read_o, write_o, error_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s done_flags got=%b want=1000",
               nm, {resp_o, read_o, write_o, error_o});
    end
    el = exp_line_q.pop_front();
    n_checks++;
    if (line_o !== el) begin
      n_fail++;
      $display("FAIL %s line got=%h want=%h", nm, line_o, el);
    end
    read_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({resp_o, read_o} !== 2'b00 || line_o !== el) begin
      n_fail++;
      $display("FAIL %s after_done resp=%b read=%b line=%h want 0,0,%h",
               nm, resp_o, read_o, line_o, el);
    end
  endtask

  task automatic write_txn(input string nm, input logic [31:0] addr,
                           input logic [255:0] line, input bit also_rd,
                           input logic [31:0] pat, input int plen);
    logic [31:0] ea;
    logic [63:0] eb;
    int beat, i, cyc;
    ea = {addr[31:5], 5'b0};
    beat = 0; i = 0; cyc = 0;
    address_i = addr;
    line_i = line;
    write_i = 1'b1;
    read_i = also_rd;
    for (int b = 0; b < 4; b++) exp_beat_q.push_back(line[b*64 +: 64]);
    @(negedge clk);
    while (beat < 4 && cyc < 64) begin
      line_i = {8{$urandom}};
      n_checks++;
      if ({read_o, write_o, resp_o} !== 3'b010) begin
        n_fail++;
        $display("FAIL %s busy_flags cyc=%0d got=%b want=010",
                 nm, cyc, {read_o, write_o, resp_o});
      end
      n_checks++;
      if (address_o !== ea) begin
        n_fail++;
        $display("FAIL %s addr cyc=%0d got=%h want=%h",
                 nm, cyc, address_o, ea);
      end
      resp_i = (i < plen) ? pat[i] : 1'b1;
      i++;
      if (resp_i) begin
        eb = exp_beat_q.pop_front();
        n_checks++;
        if (burst_o !== eb) begin
          n_fail++;
          $display("FAIL %s beat%0d got=%h want=%h", nm, beat, burst_o, eb);
        end
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    resp_i = 1'b0;
    n_checks++;
    if (beat < 4) begin
      n_fail++;
      $display("FAIL %s burst_timeout got=%0d want=4 beats", nm, beat);
    end
    n_checks++;
    if ({resp_o, read_o, write_o, error_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s done_flags got=%b want=1000",
               nm, {resp_o, read_o, write_o, error_o});
    end
    write_i = 1'b0;
    read_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({resp_o, read_o, write_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s after_done got=%b want=000",
               nm, {resp_o, read_o, write_o});
    end
  endtask

  localparam logic [255:0] RLINE = {
    {16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [255:0] WLINE = {
    64'hDEAD_0000_0000_0004, 64'h0000_0000_0000_0003,
    64'h0000_0000_0000_0002, 64'h0000_0000_0001_BEEF};

  task automatic test_read();
    read_txn("read", 32'h1234_5678, RLINE, 32'hFFFF_FFFF, 4, 1'b0);
  endtask

  task automatic test_write();
    write_txn("write", 32'h0000_00A4, WLINE, 1'b0, 32'hFFFF_FFFF, 4);
  endtask

  task automatic test_priority();
    write_txn("both_req", 32'h0000_1FFF, ~WLINE, 1'b1, 32'd89, 7);
  endtask

  task automatic test_gap_read();
    read_txn("gap_read", 32'hCAFE_F00D,
             {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom},
             32'd89, 7, 1'b1);
  endtask

  task automatic test_reset_mid();
    address_i = 32'h8000_0040;
    read_i = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      resp_i = 1'b1;
      burst_i = RLINE[b*64 +: 64];
      @(negedge clk);
    end
    resp_i = 1'b0;
    n_checks++;
    if (line_o[127:0] !== RLINE[127:0]) begin
      n_fail++;
      $display("FAIL mid_partial got=%h want=%h", line_o[127:0], RLINE[127:0]);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({read_o, write_o, resp_o, error_o} !== 4'b0 ||
        address_o !== 32'h0 || line_o !== 256'h0) begin
      n_fail++;
      $display("FAIL mid_reset flags=%b addr=%h line=%h want all 0",
               {read_o, write_o, resp_o, error_o}, address_o, line_o);
    end
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    read_txn("after_reset", 32'h0000_0100, ~RLINE, 32'hFFFF_FFFF, 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    read_txn("b2b_rd", 32'h0000_0020, WLINE, 32'd5, 3, 1'b0);
    write_txn("b2b_wr", 32'h0000_0040, RLINE, 1'b0, 32'd2, 2);
    read_txn("b2b_rd2", 32'hFFFF_FFFF, RLINE ^ WLINE, 32'hFFFF_FFFF, 4, 1'b0);
  endtask

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  task automatic test_timeout();
    address_i = 32'h0000_0300;
    read_i = 1'b1;
    @(negedge clk);
    resp_i = 1'b1;
    burst_i = 64'hABCD;
    @(negedge clk);
    resp_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (resp_o !== 1'b0) begin
        n_fail++;
        $display("FAIL to_early k=%0d got=%b want=0", k, resp_o);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({resp_o, error_o} !== 2'b11 || line_o[63:0] !== 64'hABCD) begin
      n_fail++;
      $display("FAIL to_done resp/err=%b line0=%h want 11,abcd",
               {resp_o, error_o}, line_o[63:0]);
    end
    read_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({resp_o, error_o, read_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL to_idle got=%b want=000", {resp_o, error_o, read_o});
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_priority();
    test_gap_read();
    test_reset_mid();
    test_back_to_back();
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
